// File: rtl/vector_pipe_stage.sv
// Elastic pipeline register: MAIN drives out_*, SKID absorbs one beat when downstream stalls; 1-cycle latency, registered in_ready.
// Optional VEC_PIPE_PERF_EN adds saturating stall_cnt / bubble_cnt outputs.
module vector_pipe_stage #(
    parameter int LANES  = 4,
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_lane_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_lane_en,
    output logic [1:0]             occupancy
`ifdef VEC_PIPE_PERF_EN
    ,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CTRL_W-1:0]      main_ctrl, skid_ctrl;
    logic [LANES*WIDTH-1:0] main_data, skid_data, masked_data;
    logic [LANES-1:0]       main_en, skid_en;
    logic                   ready_q;

    logic accept, drain;
    assign accept = in_valid & ready_q;
    assign drain  = (state != EMPTY) & out_ready;

    // Disabled lanes are captured as zero so downstream never sees stale lane data.
    always_comb begin
        masked_data = '0;
        for (int k = 0; k < LANES; k++) begin
            masked_data[k*WIDTH +: WIDTH] = in_lane_en[k] ? in_data[k*WIDTH +: WIDTH] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != FULL);
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_nx = ONE;
                ONE:     if (accept && !drain) state_nx = FULL;
                         else if (!accept && drain) state_nx = EMPTY;
                FULL:    if (drain) state_nx = ONE;
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid   = (state != EMPTY);
        occupancy   = state;
        in_ready    = ready_q;
        out_ctrl    = main_ctrl;
        out_data    = main_data;
        out_lane_en = main_en;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_ctrl <= '0;
            main_data <= '0;
            main_en   <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_en   <= '0;
        end else if (!flush) begin
            if (accept && (state == EMPTY || drain)) begin
                main_ctrl <= in_ctrl;
                main_data <= masked_data;
                main_en   <= in_lane_en;
            end else if (state == FULL && drain) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
                main_en   <= skid_en;
            end
            if (accept && state == ONE && !drain) begin
                skid_ctrl <= in_ctrl;
                skid_data <= masked_data;
                skid_en   <= in_lane_en;
            end
        end
    end

`ifdef VEC_PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid && !flush && bubble_cnt != 32'hFFFF_FFFF)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
